// File: rtl/alu_request_arbiter_if.sv
// Request/response handshake and ALU-side bus of the shared-ALU arbiter.
// Flat per-requester buses: slice i of each vector belongs to requester i.
interface alu_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_x;
  logic                      rsp_z;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [2:0]                alu_op;
  logic [DATA_W-1:0]         alu_x;
  logic                      alu_z;
  logic                      busy;
  logic [IDW-1:0]            grant_id;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_x, alu_z,
    output req_ready, rsp_valid, rsp_x, rsp_z, alu_a, alu_b, alu_op, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_x, alu_z,
    input  req_ready, rsp_valid, rsp_x, rsp_z, alu_a, alu_b, alu_op, busy, grant_id
  );
endinterface

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NUM_REQ requesters,
// one operation in flight: IDLE -> ISSUE -> WAIT -> RESP.
module alu_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input logic                   clk,
  input logic                   resetn,
  alu_request_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_x_q, rsp_x_d;
  logic              rsp_z_q, rsp_z_d;

  logic              found;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    cand;

  // First valid requester after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Operands go straight into the ALU-facing registers at grant, so they
  // appear during ISSUE and hold afterwards; the opcode reverts to 3'b111.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = 3'b111;
    rsp_x_d  = rsp_x_q;
    rsp_z_d  = rsp_z_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gid_d    = pick;
          alu_a_d  = DATA_W'(bus.req_a >> (32'(pick) * DATA_W));
          alu_b_d  = DATA_W'(bus.req_b >> (32'(pick) * DATA_W));
          alu_op_d = 3'(bus.req_op >> (32'(pick) * 3));
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        rsp_x_d = bus.alu_x;
        rsp_z_d = bus.alu_z;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready[gid_q]) begin
          ptr_d   = gid_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDW'(NUM_REQ - 1);
      gid_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b111;
      rsp_x_q  <= '0;
      rsp_z_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rsp_x_q  <= rsp_x_d;
      rsp_z_q  <= rsp_z_d;
    end
  end

  // req_ready is the only combinational output; it is masked while in reset.
  assign bus.req_ready = (resetn && state_q == S_IDLE && found) ? (NUM_REQ'(1) << pick) : '0;
  assign bus.rsp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << gid_q) : '0;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant_id  = gid_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench for alu_request_arbiter with a behavioural ALU stub
// and a transaction-level round-robin/result model.
module tb_alu_request_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  int   model_ptr;

  logic [31:0] opa [NR];
  logic [31:0] opb [NR];
  logic [2:0]  opc [NR];

  alu_request_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  alu_request_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {zero, result} of the external ALU
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] x;
    case (op)
      3'd0:    x = a + b;
      3'd1:    x = a - b;
      3'd2:    x = a & b;
      3'd3:    x = a | b;
      3'd4:    x = a ^ b;
      3'd5:    x = a << b[4:0];
      3'd6:    x = a >> b[4:0];
      default: x = '0;
    endcase
    return {(x == 32'd0), x};
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (ptr + k) % NR;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) {bus.alu_z, bus.alu_x} <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic drive_ops(input logic [3:0] mask);
    bus.req_valid = mask;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW +: DW] = opa[i];
      bus.req_b[i*DW +: DW] = opb[i];
      bus.req_op[i*3 +: 3]  = opc[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
      opc[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // One full operation starting in an IDLE cycle; returns at the start of the
  // cycle following the response handshake.
  task automatic transact(input logic [3:0] mask, input int g, input int stall);
    logic [31:0] ea, eb, ex;
    logic [2:0]  eop;
    logic        ez;
    logic [3:0]  oh;
    drive_ops(mask);
    bus.rsp_ready = '0;
    ea = opa[g]; eb = opb[g]; eop = opc[g];
    {ez, ex} = alu_ref(ea, eb, eop);
    oh = 4'(1) << g;
    @(negedge clk);
    tests++; if (bus.req_ready !== oh) begin fails++; $display("FAIL req_ready_grant: got %b want %b", bus.req_ready, oh); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_idle: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW +: DW] = $urandom;
      bus.req_b[i*DW +: DW] = $urandom;
      bus.req_op[i*3 +: 3]  = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    tests++; if (bus.alu_a !== ea) begin fails++; $display("FAIL alu_a_issue: got %h want %h", bus.alu_a, ea); end
    tests++; if (bus.alu_b !== eb) begin fails++; $display("FAIL alu_b_issue: got %h want %h", bus.alu_b, eb); end
    tests++; if (bus.alu_op !== eop) begin fails++; $display("FAIL alu_op_issue: got %b want %b", bus.alu_op, eop); end
    tests++; if (bus.grant_id !== 2'(g)) begin fails++; $display("FAIL grant_id: got %0d want %0d", bus.grant_id, g); end
    tests++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL req_ready_issue: got %b want 0", bus.req_ready); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_issue: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (bus.alu_op !== 3'b111) begin fails++; $display("FAIL alu_op_wait: got %b want 111", bus.alu_op); end
    tests++; if (bus.rsp_valid !== 4'b0) begin fails++; $display("FAIL rsp_valid_wait: got %b want 0", bus.rsp_valid); end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      bus.rsp_ready = 4'($urandom) & ~oh;
      @(negedge clk);
      tests++; if (bus.rsp_valid !== oh) begin fails++; $display("FAIL rsp_valid_stall: got %b want %b", bus.rsp_valid, oh); end
      tests++; if (bus.rsp_x !== ex || bus.rsp_z !== ez) begin fails++; $display("FAIL rsp_stall: got %h/%b want %h/%b", bus.rsp_x, bus.rsp_z, ex, ez); end
      tests++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL req_ready_stall: got %b want 0", bus.req_ready); end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 4'($urandom) | oh;
    @(negedge clk);
    tests++; if (bus.rsp_valid !== oh) begin fails++; $display("FAIL rsp_valid: got %b want %b", bus.rsp_valid, oh); end
    tests++; if (bus.rsp_x !== ex) begin fails++; $display("FAIL rsp_x: got %h want %h", bus.rsp_x, ex); end
    tests++; if (bus.rsp_z !== ez) begin fails++; $display("FAIL rsp_z: got %b want %b", bus.rsp_z, ez); end
    tests++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL req_ready_resp: got %b want 0", bus.req_ready); end
    model_ptr = g;
    @(posedge clk); #1;
    bus.rsp_ready = '0;
    bus.req_valid = '0;
  endtask

  task automatic idle_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_idle_cycle: got %b want 0", bus.busy); end
    tests++; if (bus.rsp_valid !== 4'b0) begin fails++; $display("FAIL rsp_valid_idle: got %b want 0", bus.rsp_valid); end
    tests++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL req_ready_idle: got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    tests++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL %s_req_ready: got %b want 0", tag, bus.req_ready); end
    tests++; if (bus.rsp_valid !== 4'b0) begin fails++; $display("FAIL %s_rsp_valid: got %b want 0", tag, bus.rsp_valid); end
    tests++; if (bus.rsp_x !== 32'd0 || bus.rsp_z !== 1'b0) begin fails++; $display("FAIL %s_rsp: got %h/%b want 0/0", tag, bus.rsp_x, bus.rsp_z); end
    tests++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin fails++; $display("FAIL %s_alu_ab: got %h/%h want 0/0", tag, bus.alu_a, bus.alu_b); end
    tests++; if (bus.alu_op !== 3'b111) begin fails++; $display("FAIL %s_alu_op: got %b want 111", tag, bus.alu_op); end
    tests++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin fails++; $display("FAIL %s_busy_gid: got %b/%0d want 0/0", tag, bus.busy, bus.grant_id); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rand_ops();
      drive_ops(4'($urandom));
      bus.rsp_ready = 4'($urandom);
      @(negedge clk);
      check_reset_values("reset");
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    model_ptr = NR - 1;
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      transact(4'b1111, seq[k], 0);
    end
    rand_ops();
    transact(4'b1010, 3, 0);
  endtask

  task automatic test_single_add();
    rand_ops();
    opa[0] = 32'd5; opb[0] = 32'd7; opc[0] = 3'b000;
    transact(4'b0001, 0, 0);
  endtask

  task automatic test_sub_edges();
    rand_ops();
    opa[2] = 32'd9; opb[2] = 32'd9; opc[2] = 3'b001;
    transact(4'b0100, 2, 0);
    opa[2] = 32'd0; opb[2] = 32'd1; opc[2] = 3'b001;
    transact(4'b0100, 2, 0);
    opa[2] = $urandom; opb[2] = $urandom; opc[2] = 3'b111;
    transact(4'b0100, 2, 1);
  endtask

  task automatic test_backpressure();
    rand_ops();
    transact(4'b0010, 1, 5);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    rand_ops();
    drive_ops(4'b0010);
    @(negedge clk);
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL rmid_grant: got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check_reset_values("rmid");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (bus.rsp_valid !== 4'b0) begin fails++; $display("FAIL rmid_hold_rsp_valid: got %b want 0", bus.rsp_valid); end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    model_ptr = NR - 1;
    idle_cycle();
    rand_ops();
    transact(4'b0011, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [3:0] mask;
      mask = 4'($urandom);
      if (mask == 4'b0) begin
        idle_cycle();
      end else begin
        rand_ops();
        if ($urandom_range(0, 3) == 0) opb[$urandom_range(0, 3)] = 32'd0;
        transact(mask, rr_pick(mask, model_ptr), int'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_ptr = NR - 1;
    resetn = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_round_robin();
    test_single_add();
    test_sub_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
Shares one registered 32-bit ALU (1-cycle latency, 3-bit opcode, zero flag) between NUM_REQ requesters. Each requester issues an operation over a valid/ready request channel and receives X/Z over a per-requester valid/ready response channel. Arbitration is round-robin with one operation in flight. The block sits between client engines and the ALU instance and is the only driver of the ALU's A/B/OP inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width; must equal the ALU width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  request valid per requester
req_ready  output  NUM_REQ  request accepted (one-hot or zero)
req_a  input  NUM_REQ*DATA_W  operand A per requester, slice i = requester i
req_b  input  NUM_REQ*DATA_W  operand B per requester
req_op  input  NUM_REQ*3  opcode per requester
rsp_valid  output  NUM_REQ  response valid (one-hot or zero)
rsp_ready  input  NUM_REQ  response accepted per requester
rsp_x  output  DATA_W  shared result bus, meaningful when any rsp_valid is high
rsp_z  output  1  zero flag of result
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_op  output  3  to ALU OP
alu_x  input  DATA_W  from ALU X (registered)
alu_z  input  1  from ALU Z
busy  output  1  high in any state other than IDLE
grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester

Behaviour:
- One clock; reset is asynchronous and active-low: clk, resetn. All state is cleared immediately on resetn low.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_x=0, rsp_z=0, alu_a=0, alu_b=0, alu_op=3'b111, busy=0, grant_id=0, RR pointer=NUM_REQ-1, so requester 0 wins first.
- alu_op is 3'b111 (ALU result 0) in every state except ISSUE. alu_a/alu_b hold their last values outside ISSUE.
- FSM:
  - IDLE: if any req_valid, pick the first set bit searching from pointer+1 upward with wrap. Drive req_ready[g]=1 combinationally in this cycle; the handshake completes in this cycle. Latch req_a/req_b/req_op slice g and grant_id=g, then go to ISSUE. With no req_valid, stay in IDLE with req_ready=0.
  - ISSUE (1 cycle): drive alu_a/alu_b/alu_op from the latched values, then go to WAIT.
  - WAIT (1 cycle): alu_x/alu_z now hold the result. Register them into rsp_x/rsp_z at the end of the cycle, then go to RESP.
  - RESP: rsp_valid[grant_id]=1, with rsp_x/rsp_z stable. On rsp_ready[grant_id], set pointer=grant_id and go to IDLE. rsp_ready on other bits is ignored.
- Latency: with the request accepted in cycle 0, the ALU sees operands in cycle 1 and rsp_valid rises in cycle 3. Minimum 4 cycles per operation (RESP handshake in cycle 3, next grant in cycle 4).
- req_ready is never asserted outside IDLE. At most one req_ready bit and one rsp_valid bit are high at any time.
- Requests are sampled only in the grant cycle. A requester may deassert req_valid before being granted without side effects.
- Opcode is passed through unchecked. Opcode 3'b111 yields x=0, z=1.
- Arithmetic (wrap, complement) is the ALU's. The arbiter never modifies the result.
- If rsp_ready is held low, the block stays in RESP indefinitely and no new request is accepted.
- Reset mid-operation: the in-flight operation is discarded with no response, and the pointer returns to NUM_REQ-1.

Test Plan:
- Reset: hold resetn=0 with random req_valid -> all outputs at reset values, alu_op=3'b111, req_ready=0.
- Single ADD: req0 A=5 B=7 OP=000 in cycle 0 -> req_ready[0] in cycle 0; alu_op=000/a=5/b=7 in cycle 1; rsp_valid[0] in cycle 3 with rsp_x=12, rsp_z=0.
- SUB edge cases: req2 9-9 -> rsp_x=0, rsp_z=1. Then req2 0-1 -> rsp_x=32'hFFFFFFFF, rsp_z=0. OP=111 -> rsp_x=0, rsp_z=1.
- Round-robin: all four req_valid held high with rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive 4-cycle slots. Then only req1 and req3 valid after a grant to 1 -> 3 is granted next.
- Backpressure: rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1] held, rsp_x stable, req_ready=0 throughout; release -> IDLE the next cycle.
- Reset during WAIT with req1 granted -> immediate reset values, no rsp_valid[1]. After release, req0 and req1 both valid -> req0 granted first.
